// File: rtl/riscv_mule_pkg.sv
// Shared types and constants for the MULE iterative multiplier scheduler.
package riscv_mule_pkg;

    localparam int XLEN              = 32;
    localparam int REG_IDX_W         = 5;
    localparam int MULE_BITS_DEFAULT = 1;

    typedef enum logic [1:0] {
        MULE_IDLE = 2'd0,
        MULE_BUSY = 2'd1,
        MULE_DONE = 2'd2
    } mule_state_e;

    // BUSY cycles needed to consume every multiplier bit
    function automatic int mule_iters(input int mule_bits);
        return XLEN / mule_bits;
    endfunction

endpackage

// File: rtl/riscv_mule_sched_if.sv
// Issue/writeback handshake bundle for the MULE scheduler.
interface riscv_mule_sched_if;
    import riscv_mule_pkg::*;

    logic                 lane0_valid_i;
    logic [XLEN-1:0]      lane0_opa_i;
    logic [XLEN-1:0]      lane0_opb_i;
    logic [REG_IDX_W-1:0] lane0_rd_i;
    logic                 lane0_accept_o;
    logic                 lane1_valid_i;
    logic [XLEN-1:0]      lane1_opa_i;
    logic [XLEN-1:0]      lane1_opb_i;
    logic [REG_IDX_W-1:0] lane1_rd_i;
    logic                 lane1_accept_o;
    logic                 flush_i;
    logic                 result_valid_o;
    logic                 result_ready_i;
    logic [XLEN-1:0]      result_value_o;
    logic [REG_IDX_W-1:0] result_rd_o;
    logic                 result_lane_o;
    logic                 busy_o;

    modport master (
        output lane0_valid_i, lane0_opa_i, lane0_opb_i, lane0_rd_i,
        output lane1_valid_i, lane1_opa_i, lane1_opb_i, lane1_rd_i,
        output flush_i, result_ready_i,
        input  lane0_accept_o, lane1_accept_o,
        input  result_valid_o, result_value_o, result_rd_o, result_lane_o, busy_o
    );

    modport slave (
        input  lane0_valid_i, lane0_opa_i, lane0_opb_i, lane0_rd_i,
        input  lane1_valid_i, lane1_opa_i, lane1_opb_i, lane1_rd_i,
        input  flush_i, result_ready_i,
        output lane0_accept_o, lane1_accept_o,
        output result_valid_o, result_value_o, result_rd_o, result_lane_o, busy_o
    );

endinterface

// File: rtl/riscv_mule_step.sv
// One shift-add iteration: consumes MULE_BITS multiplier bits per call.
module riscv_mule_step
    import riscv_mule_pkg::*;
#(
    parameter int MULE_BITS = MULE_BITS_DEFAULT
) (
    input  logic [XLEN-1:0] acc,
    input  logic [XLEN-1:0] opa_sh,
    input  logic [XLEN-1:0] opb_sh,
    output logic [XLEN-1:0] acc_nxt,
    output logic [XLEN-1:0] opa_nxt,
    output logic [XLEN-1:0] opb_nxt
);

    logic [XLEN-1:0] digit;

    assign digit   = {{(XLEN-MULE_BITS){1'b0}}, opb_sh[MULE_BITS-1:0]};
    assign acc_nxt = acc + opa_sh * digit;
    assign opa_nxt = opa_sh << MULE_BITS;
    assign opb_nxt = opb_sh >> MULE_BITS;

endmodule

// File: rtl/riscv_mule_sched.sv
// Two-lane scheduler/sequencer for the shared iterative multiplier.
// Optional early completion on exhausted multiplier: define MULE_EARLY_OUT_EN.
module riscv_mule_sched
    import riscv_mule_pkg::*;
#(
    parameter int MULE_BITS = MULE_BITS_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_i,
    riscv_mule_sched_if.slave  bus
);

    localparam int ITERS = mule_iters(MULE_BITS);
    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

    mule_state_e          state_q;
    logic                 last_grant_q;
    logic [XLEN-1:0]      acc_q;
    logic [XLEN-1:0]      opa_q;
    logic [XLEN-1:0]      opb_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [REG_IDX_W-1:0] rd_q;
    logic                 lane_q;
    logic                 valid_q;

    logic                 grant_lane;
    logic                 take;
    logic                 step_last;
    logic [XLEN-1:0]      acc_nxt;
    logic [XLEN-1:0]      opa_nxt;
    logic [XLEN-1:0]      opb_nxt;

    // Round-robin only matters when both lanes compete
    assign grant_lane = (bus.lane0_valid_i && bus.lane1_valid_i) ? ~last_grant_q
                                                                 : bus.lane1_valid_i;
    assign take = !rst_i && (state_q == MULE_IDLE) && !bus.flush_i &&
                  (bus.lane0_valid_i || bus.lane1_valid_i);

    assign bus.lane0_accept_o = take && !grant_lane;
    assign bus.lane1_accept_o = take &&  grant_lane;
    assign bus.result_valid_o = valid_q;
    assign bus.result_value_o = acc_q;
    assign bus.result_rd_o    = rd_q;
    assign bus.result_lane_o  = lane_q;
    assign bus.busy_o         = (state_q != MULE_IDLE);

    riscv_mule_step #(.MULE_BITS(MULE_BITS)) u_step (
        .acc     (acc_q),
        .opa_sh  (opa_q),
        .opb_sh  (opb_q),
        .acc_nxt (acc_nxt),
        .opa_nxt (opa_nxt),
        .opb_nxt (opb_nxt)
    );

`ifdef MULE_EARLY_OUT_EN
    assign step_last = (cnt_q == '0) || (opb_nxt == '0);
`else
    assign step_last = (cnt_q == '0);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= MULE_IDLE;
            last_grant_q <= 1'b1;
            acc_q        <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            cnt_q        <= '0;
            rd_q         <= '0;
            lane_q       <= 1'b0;
            valid_q      <= 1'b0;
        end else if (bus.flush_i) begin
            state_q <= MULE_IDLE;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                MULE_IDLE: begin
                    if (take) begin
                        opa_q        <= grant_lane ? bus.lane1_opa_i : bus.lane0_opa_i;
                        opb_q        <= grant_lane ? bus.lane1_opb_i : bus.lane0_opb_i;
                        rd_q         <= grant_lane ? bus.lane1_rd_i  : bus.lane0_rd_i;
                        lane_q       <= grant_lane;
                        acc_q        <= '0;
                        cnt_q        <= CNT_W'(ITERS - 1);
                        last_grant_q <= grant_lane;
                        state_q      <= MULE_BUSY;
                    end
                end
                MULE_BUSY: begin
                    acc_q <= acc_nxt;
                    opa_q <= opa_nxt;
                    opb_q <= opb_nxt;
                    if (step_last) begin
                        state_q <= MULE_DONE;
                        valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                MULE_DONE: begin
                    // Result fields hold until writeback takes them
                    if (bus.result_ready_i) begin
                        state_q <= MULE_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= MULE_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mule_sched.sv
// Directed plus randomized bench for riscv_mule_sched against a product/latency model.
module tb_riscv_mule_sched;
    import riscv_mule_pkg::*;

    localparam int MB    = 1;
    localparam int ITERS = XLEN / MB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic last_g = 1'b1;

    riscv_mule_sched_if bus();

    riscv_mule_sched #(.MULE_BITS(MB)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input logic [31:0] b);
`ifdef MULE_EARLY_OUT_EN
        int msb;
        msb = -1;
        for (int i = 0; i < 32; i++) if (b[i]) msb = i;
        if (msb < 0) return 2;
        return 1 + (msb + MB) / MB;
`else
        return ITERS + 1;
`endif
    endfunction

    function automatic logic [31:0] exp_prod(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        return p[31:0];
    endfunction

    task automatic set_lane(input int lane, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd);
        if (lane == 0) begin
            bus.lane0_valid_i = 1'b1; bus.lane0_opa_i = a; bus.lane0_opb_i = b; bus.lane0_rd_i = rd;
        end else begin
            bus.lane1_valid_i = 1'b1; bus.lane1_opa_i = a; bus.lane1_opb_i = b; bus.lane1_rd_i = rd;
        end
    endtask

    // Called in an IDLE cycle with lane requests already driven
    task automatic do_txn(input int hold);
        logic        g;
        logic [31:0] a, b, ev;
        logic [4:0]  rd;
        logic        bad;
        int          lat, n;
        g   = (bus.lane0_valid_i && bus.lane1_valid_i) ? !last_g : bus.lane1_valid_i;
        a   = g ? bus.lane1_opa_i : bus.lane0_opa_i;
        b   = g ? bus.lane1_opb_i : bus.lane0_opb_i;
        rd  = g ? bus.lane1_rd_i  : bus.lane0_rd_i;
        ev  = exp_prod(a, b);
        lat = exp_lat(b);
        bus.result_ready_i = (hold == 0);
        #1;
        chk("accept0", bus.lane0_accept_o, !g);
        chk("accept1", bus.lane1_accept_o, g);
        last_g = g;
        @(posedge clk); #1;
        if (g) bus.lane1_valid_i = 1'b0; else bus.lane0_valid_i = 1'b0;
        n = 1; bad = 1'b0;
        while (!bus.result_valid_o && n < 200) begin
            if (!bus.busy_o || bus.lane0_accept_o || bus.lane1_accept_o) bad = 1'b1;
            @(posedge clk); #1; n++;
        end
        chk("latency", n, lat);
        chk("value", bus.result_value_o, ev);
        chk("rd", bus.result_rd_o, rd);
        chk("lane", bus.result_lane_o, g);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!bus.result_valid_o || !bus.busy_o || bus.result_value_o !== ev ||
                bus.result_rd_o !== rd || bus.result_lane_o !== g ||
                bus.lane0_accept_o || bus.lane1_accept_o) bad = 1'b1;
        end
        chk("busy_hold_stable", bad, 1'b0);
        bus.result_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.result_ready_i = 1'b0;
        chk("valid_drop", bus.result_valid_o, 1'b0);
        chk("idle_after", bus.busy_o, 1'b0);
    endtask

    initial begin
        logic saw;
        int   sel;
        bus.lane0_valid_i = 0; bus.lane0_opa_i = 0; bus.lane0_opb_i = 0; bus.lane0_rd_i = 0;
        bus.lane1_valid_i = 0; bus.lane1_opa_i = 0; bus.lane1_opb_i = 0; bus.lane1_rd_i = 0;
        bus.flush_i = 0; bus.result_ready_i = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy_o, 1'b0);
        chk("rst_valid", bus.result_valid_o, 1'b0);
        chk("rst_value", bus.result_value_o, 32'd0);
        chk("rst_rd", bus.result_rd_o, 5'd0);
        chk("rst_lane", bus.result_lane_o, 1'b0);

        // Both lanes pending across reset release
        set_lane(0, 32'd3, 32'd5, 5'd3);
        set_lane(1, 32'd4, 32'd4, 5'd4);
        #1;
        chk("rst_accept", {bus.lane0_accept_o, bus.lane1_accept_o}, 2'b00);
        @(posedge clk); #1;
        rst = 1'b0;
        do_txn(0);
        do_txn(0);
        set_lane(0, 32'd2, 32'd9, 5'd7);
        set_lane(1, 32'd5, 32'd5, 5'd8);
        do_txn(0);
        bus.lane1_valid_i = 1'b0;

        set_lane(0, 32'd7, 32'd6, 5'd12); do_txn(0);
        set_lane(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1); do_txn(0);
        set_lane(1, 32'h0001_0000, 32'h0001_0000, 5'd2); do_txn(0);

        // Backpressure with the other lane waiting throughout DONE
        set_lane(0, 32'd11, 32'd13, 5'd20);
        set_lane(1, 32'd17, 32'd19, 5'd21);
        do_txn(10);
        do_txn(2);

        set_lane(0, 32'd9, 32'd0, 5'd5); do_txn(0);
        set_lane(0, 32'd9, 32'd3, 5'd6); do_txn(0);

        // Flush mid-operation
        set_lane(0, 32'd123, 32'd456, 5'd9);
        #1;
        chk("flush_acc", bus.lane0_accept_o, 1'b1);
        last_g = 1'b0;
        @(posedge clk); #1;
        bus.lane0_valid_i = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        bus.flush_i = 1'b1;
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        chk("flush_idle", bus.busy_o, 1'b0);
        saw = 1'b0;
        repeat (40) begin
            if (bus.result_valid_o) saw = 1'b1;
            @(posedge clk); #1;
        end
        chk("flush_no_result", saw, 1'b0);

        // Flush in IDLE blocks the accept
        set_lane(0, 32'd1, 32'd1, 5'd1);
        bus.flush_i = 1'b1;
        #1;
        chk("flush_idle_acc", bus.lane0_accept_o, 1'b0);
        @(posedge clk); #1;
        chk("flush_idle_busy", bus.busy_o, 1'b0);
        bus.flush_i = 1'b0;
        bus.lane0_valid_i = 1'b0;

        // Reset mid-operation restores lane 0 priority
        set_lane(1, 32'd8, 32'd8, 5'd3);
        #1;
        chk("rstmid_acc", bus.lane1_accept_o, 1'b1);
        @(posedge clk); #1;
        bus.lane1_valid_i = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        last_g = 1'b1;
        chk("rstmid_busy", bus.busy_o, 1'b0);
        chk("rstmid_valid", bus.result_valid_o, 1'b0);
        set_lane(0, 32'd6, 32'd7, 5'd10);
        set_lane(1, 32'd2, 32'd3, 5'd11);
        do_txn(0);
        do_txn(1);

        for (int k = 0; k < 24; k++) begin
            for (int ln = 0; ln < 2; ln++) begin
                logic [31:0] a, b;
                a   = $urandom;
                sel = $urandom_range(0, 3);
                b   = (sel == 0) ? 32'd0 : (sel == 1) ? ($urandom >> $urandom_range(0, 31)) : $urandom;
                if (ln == 1 || $urandom_range(0, 1) == 1)
                    set_lane(ln, a, b, 5'($urandom_range(0, 31)));
            end
            if (!bus.lane0_valid_i && !bus.lane1_valid_i) bus.lane0_valid_i = 1'b1;
            do_txn($urandom_range(0, 3));
            bus.lane0_valid_i = 1'b0;
            bus.lane1_valid_i = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
